control_mc: RTL and testbench

//  Multicycle control unit for the RV32I core; next generation of the combinational decoder.

---
 rtl/ctrl_pkg.sv | 74 +++++++
 rtl/ctrl_decode.sv | 32 +++
 rtl/control_mc.sv | 238 +++++++++++++++++++++++
 tb/tb_control_mc.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg
//   Shared definitions for the multicycle RV32I control unit and the datapath
//   it drives. This file holds the following:
//     state_t      - control FSM states
//     class_t      - instruction class latched in DECODE
//     OP_*         - base opcodes recognised by the decoder
//     ALUO_*       - ALUo encodings (ALU operation select)
//     MTR_*        - mtr encodings (write-back source select)
//     PCSRC_*      - pc_src encodings (next-PC select)
//     CAUSE_*      - trap_cause encodings
//     alu_op_for() - ALUo value for an ALU-class instruction
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_t;

   typedef enum logic [3:0] {
      CLS_NONE,
      CLS_R,
      CLS_LOAD,
      CLS_IMATH,
      CLS_STORE,
      CLS_BR,
      CLS_JAL,
      CLS_JALR,
      CLS_LUI,
      CLS_AUIPC
   } class_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_IMATH = 7'b0010011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [1:0] ALUO_ADD   = 2'b00;
   localparam logic [1:0] ALUO_BR    = 2'b01;
   localparam logic [1:0] ALUO_R     = 2'b10;
   localparam logic [1:0] ALUO_IMATH = 2'b11;

   localparam logic [1:0] MTR_ALU = 2'b00;
   localparam logic [1:0] MTR_MEM = 2'b01;
   localparam logic [1:0] MTR_PC4 = 2'b10;

   localparam logic [1:0] PCSRC_PC4     = 2'b00;
   localparam logic [1:0] PCSRC_PC_IMM  = 2'b01;
   localparam logic [1:0] PCSRC_RS1_IMM = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_BUS     = 2'b10;

   // LUI and AUIPC both use a plain add: LUI adds to a zeroed A operand and
   // AUIPC adds to the PC. The datapath selects the A operand.
   function automatic logic [1:0] alu_op_for(class_t cls);
      case (cls)
         CLS_R:     return ALUO_R;
         CLS_IMATH: return ALUO_IMATH;
         default:   return ALUO_ADD;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
//   Combinational opcode classifier used in the DECODE state.
//   Ports:
//     opcode   in  7  IR[6:0]
//     cls      out    instruction class (CLS_NONE for an unknown opcode)
//     illegal  out 1  opcode is not one of the supported RV32I base classes
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output class_t     cls,
   output logic       illegal
);

   always_comb begin
      case (opcode)
         OP_R:     cls = CLS_R;
         OP_LOAD:  cls = CLS_LOAD;
         OP_IMATH: cls = CLS_IMATH;
         OP_STORE: cls = CLS_STORE;
         OP_BR:    cls = CLS_BR;
         OP_JAL:   cls = CLS_JAL;
         OP_JALR:  cls = CLS_JALR;
         OP_LUI:   cls = CLS_LUI;
         OP_AUIPC: cls = CLS_AUIPC;
         default:  cls = CLS_NONE;
      endcase
   end

   assign illegal = (cls == CLS_NONE);

endmodule

// File: rtl/control_mc.sv
// control_mc
//   Multicycle control unit for the RV32I core. It sequences each instruction
//   through FETCH / DECODE / EXEC / MEM / WB and drives the datapath enables
//   and mux selects. It waits on mem_ready for instruction and data accesses.
//   A bus timeout is optional. An illegal opcode causes a trap. The unit also
//   counts retired instructions.
//   Parameters:
//     MEM_TIMEOUT  not-ready cycles before a bus-error trap (0 = wait forever)
//     WB_MERGE     1 = ALU-class results written back in EXEC
//     CNT_W        width of the retired-instruction counter
//   Ports:
//     clk, rst               clock, asynchronous active-high reset
//     opcode, funct3         instruction fields, valid from DECODE onward
//     br_cond                branch comparator result
//     mem_ready              memory completes the current request
//     trap_clr               leave the TRAP state
//     mem_req, mem_we        memory request / store
//     ir_we, pc_we, pc_src   instruction-register and PC control
//     rf_we, mtr             register-file write and write-back source
//     ALUo, ALUs             ALU operation and B-operand-is-immediate
//     BranchType, MemType    funct3 latched at DECODE
//     trap, trap_cause       trap state and its cause
//     instret                retired-instruction count (wraps)
module control_mc
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int WB_MERGE    = 0,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             br_cond,
   input  logic             mem_ready,
   input  logic             trap_clr,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             rf_we,
   output logic [1:0]       ALUo,
   output logic             ALUs,
   output logic [1:0]       mtr,
   output logic [2:0]       BranchType,
   output logic [2:0]       MemType,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   // The counter only needs to reach MEM_TIMEOUT-1: expiry is detected on
   // the not-ready cycle that would make the count equal MEM_TIMEOUT.
   localparam int TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST =
      TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t           state;
   state_t           next_state;
   class_t           cls_q;
   class_t           dec_cls;
   logic             dec_illegal;
   logic [2:0]       f3_q;
   logic [1:0]       cause_q;
   logic [1:0]       cause_set;
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_expire;
   logic             mem_wait;
   logic             retire;

   ctrl_decode u_decode (
      .opcode  (opcode),
      .cls     (dec_cls),
      .illegal (dec_illegal)
   );

   // A memory wait cycle is any FETCH or MEM cycle without mem_ready. When
   // mem_ready arrives in the same cycle as expiry, the access still wins,
   // because expiry only applies to a not-ready cycle.
   assign mem_wait   = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
   assign tmo_expire = (MEM_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

   // An instruction retires on its last cycle. That is the cycle that hands
   // control back to FETCH from EXEC, MEM or WB. Leaving TRAP or RESET does
   // not retire an instruction.
   assign retire = (next_state == ST_FETCH) &&
                   ((state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB));

   assign BranchType = f3_q;
   assign MemType    = f3_q;

   // NOTE: every signal written here gets a default first. Without that, a
   // path that skips an assignment would infer a latch.
   always_comb begin
      next_state = state;
      cause_set  = CAUSE_NONE;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PCSRC_PC4;
      rf_we      = 1'b0;
      ALUo       = ALUO_ADD;
      ALUs       = 1'b0;
      mtr        = MTR_ALU;
      trap       = 1'b0;
      trap_cause = CAUSE_NONE;

      case (state)
         ST_RESET: next_state = ST_FETCH;

         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we      = 1'b1;
               pc_we      = 1'b1;
               pc_src     = PCSRC_PC4;
               next_state = ST_DECODE;
            end else if (tmo_expire) begin
               next_state = ST_TRAP;
               cause_set  = CAUSE_BUS;
            end
         end

         ST_DECODE: begin
            if (dec_illegal) begin
               next_state = ST_TRAP;
               cause_set  = CAUSE_ILLEGAL;
            end else begin
               next_state = ST_EXEC;
            end
         end

         ST_EXEC: begin
            case (cls_q)
               CLS_BR: begin
                  ALUo       = ALUO_BR;
                  pc_we      = br_cond;
                  pc_src     = PCSRC_PC_IMM;
                  next_state = ST_FETCH;
               end
               CLS_JAL, CLS_JALR: begin
                  pc_we      = 1'b1;
                  pc_src     = (cls_q == CLS_JAL) ? PCSRC_PC_IMM : PCSRC_RS1_IMM;
                  rf_we      = 1'b1;
                  mtr        = MTR_PC4;
                  next_state = ST_FETCH;
               end
               CLS_LOAD, CLS_STORE: begin
                  ALUo       = ALUO_ADD;
                  ALUs       = 1'b1;
                  next_state = ST_MEM;
               end
               CLS_R, CLS_IMATH, CLS_LUI, CLS_AUIPC: begin
                  ALUo = alu_op_for(cls_q);
                  ALUs = (cls_q != CLS_R);
                  if (WB_MERGE != 0) begin
                     rf_we      = 1'b1;
                     mtr        = MTR_ALU;
                     next_state = ST_FETCH;
                  end else begin
                     next_state = ST_WB;
                  end
               end
               // DECODE never lets an illegal class reach EXEC. This branch
               // only makes sure a corrupted class cannot stall the core.
               default: next_state = ST_FETCH;
            endcase
         end

         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = (cls_q == CLS_STORE);
            if (mem_ready) begin
               next_state = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
            end else if (tmo_expire) begin
               next_state = ST_TRAP;
               cause_set  = CAUSE_BUS;
            end
         end

         ST_WB: begin
            rf_we      = 1'b1;
            mtr        = (cls_q == CLS_LOAD) ? MTR_MEM : MTR_ALU;
            next_state = ST_FETCH;
         end

         ST_TRAP: begin
            trap       = 1'b1;
            trap_cause = cause_q;
            if (trap_clr) next_state = ST_FETCH;
         end

         default: next_state = ST_RESET;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments. Every register
   // then samples the pre-edge values, whatever the statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_RESET;
         cls_q   <= CLS_NONE;
         f3_q    <= 3'b000;
         cause_q <= CAUSE_NONE;
         tmo_cnt <= '0;
         instret <= '0;
      end else begin
         state <= next_state;

         if (state == ST_DECODE) begin
            cls_q <= dec_cls;
            f3_q  <= funct3;
         end

         // The cause is captured on entry to TRAP and held there. It is
         // cleared on the cycle that leaves TRAP.
         if (state == ST_TRAP) begin
            if (trap_clr) cause_q <= CAUSE_NONE;
         end else begin
            cause_q <= cause_set;
         end

         // Every cycle that is not a wait cycle clears the counter. So it is
         // always zero when FETCH or MEM is entered.
         if (mem_wait && (MEM_TIMEOUT != 0)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end else begin
            tmo_cnt <= '0;
         end

         if (retire) instret <= instret + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_control_mc.sv
// tb_control_mc
//   Directed bench for control_mc (MEM_TIMEOUT=4, WB_MERGE=0). For each
//   instruction, the bench builds a per-cycle timeline from the instruction-
//   level rules: the inputs to drive and the outputs expected. The bench then
//   plays the timeline back. One process compares every output on each
//   falling edge. A few literal checks pin the model.
module tb_control_mc;

   localparam int TMO   = 4;
   localparam int CNT_W = 32;

   localparam logic [6:0] R_OP   = 7'b0110011;
   localparam logic [6:0] LD_OP  = 7'b0000011;
   localparam logic [6:0] IM_OP  = 7'b0010011;
   localparam logic [6:0] ST_OP  = 7'b0100011;
   localparam logic [6:0] BR_OP  = 7'b1100011;
   localparam logic [6:0] JAL_OP = 7'b1101111;
   localparam logic [6:0] JR_OP  = 7'b1100111;
   localparam logic [6:0] LUI_OP = 7'b0110111;
   localparam logic [6:0] AUI_OP = 7'b0010111;
   localparam logic [6:0] BAD_OP = 7'b1111111;

   logic             clk = 1'b0;
   logic             rst;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             br_cond;
   logic             mem_ready;
   logic             trap_clr;
   logic             mem_req, mem_we, ir_we, pc_we, rf_we, ALUs, trap;
   logic [1:0]       pc_src, ALUo, mtr, trap_cause;
   logic [2:0]       BranchType, MemType;
   logic [CNT_W-1:0] instret;

   always #5 clk = ~clk;

   control_mc #(.MEM_TIMEOUT(TMO), .WB_MERGE(0), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct3     (funct3),
      .br_cond    (br_cond),
      .mem_ready  (mem_ready),
      .trap_clr   (trap_clr),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .rf_we      (rf_we),
      .ALUo       (ALUo),
      .ALUs       (ALUs),
      .mtr        (mtr),
      .BranchType (BranchType),
      .MemType    (MemType),
      .trap       (trap),
      .trap_cause (trap_cause),
      .instret    (instret)
   );

   // Printed in binary in this field order on a miscompare.
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       rf_we;
      logic [1:0] aluo;
      logic       alus;
      logic [1:0] mtr;
      logic [2:0] bt;
      logic [2:0] mt;
      logic       trap;
      logic [1:0] cause;
   } outs_t;

   typedef struct {
      logic  ready;
      logic  brc;
      logic  tclr;
      outs_t o;
      bit    retire;
   } cyc_t;

   outs_t       dut_o;
   cyc_t        tl[$];
   logic [2:0]  m_f3;
   logic [31:0] m_instret;
   logic [6:0]  cur_op;
   logic [2:0]  cur_f3;
   outs_t       exp_o;
   logic [31:0] exp_ir;
   bit          chk_en;
   int          n_tests;
   int          n_fail;

   assign dut_o = {mem_req, mem_we, ir_we, pc_we, pc_src, rf_we, ALUo, ALUs,
                   mtr, BranchType, MemType, trap, trap_cause};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("outs", 64'(dut_o), 64'(exp_o));
         check("instret", 64'(instret), 64'(exp_ir));
      end
   end

   // ---------------- instruction-level model ----------------
   function automatic outs_t base();
      outs_t o = '0;
      o.bt = m_f3;
      o.mt = m_f3;
      return o;
   endfunction

   function automatic void add(input logic r, input logic b, input logic t,
                               input outs_t o, input bit ret);
      cyc_t c;
      c.ready  = r;
      c.brc    = b;
      c.tclr   = t;
      c.o      = o;
      c.retire = ret;
      tl.push_back(c);
   endfunction

   // TRAP is held for 'hold' cycles with mem_ready high (ignored). Then a
   // trap_clr cycle follows.
   function automatic void add_trap(input logic [1:0] cause, input int hold);
      outs_t o = base();
      o.trap  = 1'b1;
      o.cause = cause;
      for (int i = 0; i < hold; i++) add(1'b1, 1'b0, 1'b0, o, 1'b0);
      add(1'b1, 1'b0, 1'b1, o, 1'b0);
   endfunction

   // Not-ready cycles of one memory access. TMO of them end in a bus trap.
   function automatic bit add_waits(input int waits, input outs_t req);
      int n = (waits < TMO) ? waits : TMO;
      for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, req, 1'b0);
      if (waits >= TMO) begin
         add_trap(2'b10, 2);
         return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void build(input logic [6:0] op, input logic [2:0] f3,
                                 input int fwait, input int mwait, input logic brc);
      outs_t o = base();
      o.mem_req = 1'b1;
      if (add_waits(fwait, o)) return;
      o.ir_we = 1'b1;
      o.pc_we = 1'b1;
      add(1'b1, 1'b0, 1'b0, o, 1'b0);
      add(1'b1, 1'b0, 1'b1, base(), 1'b0);   // DECODE: mem_ready/trap_clr ignored
      m_f3 = f3;
      o = base();
      case (op)
         BR_OP: begin
            o.aluo = 2'b01; o.pc_we = brc; o.pc_src = 2'b01;
            add(1'b1, brc, 1'b0, o, 1'b1);
         end
         JAL_OP, JR_OP: begin
            o.pc_we = 1'b1; o.rf_we = 1'b1; o.mtr = 2'b10;
            o.pc_src = (op == JAL_OP) ? 2'b01 : 2'b10;
            add(1'b1, 1'b0, 1'b0, o, 1'b1);
         end
         LD_OP, ST_OP: begin
            o.alus = 1'b1;
            add(1'b1, 1'b0, 1'b0, o, 1'b0);
            o = base();
            o.mem_req = 1'b1;
            o.mem_we  = (op == ST_OP);
            if (add_waits(mwait, o)) return;
            add(1'b1, 1'b0, 1'b0, o, op == ST_OP);
            if (op == LD_OP) begin
               o = base(); o.rf_we = 1'b1; o.mtr = 2'b01;
               add(1'b1, 1'b0, 1'b0, o, 1'b1);
            end
         end
         R_OP, IM_OP, LUI_OP, AUI_OP: begin
            o.aluo = (op == R_OP) ? 2'b10 : (op == IM_OP) ? 2'b11 : 2'b00;
            o.alus = (op != R_OP);
            add(1'b1, 1'b0, 1'b0, o, 1'b0);
            o = base(); o.rf_we = 1'b1;
            add(1'b1, 1'b0, 1'b0, o, 1'b1);
         end
         default: add_trap(2'b01, 3);
      endcase
   endfunction

   // Play the timeline back. Inputs change 1 after the rising edge, and the
   // compare process samples on the falling edge.
   task automatic run();
      cyc_t c;
      chk_en = 1'b1;
      while (tl.size() > 0) begin
         c         = tl.pop_front();
         opcode    = cur_op;
         funct3    = cur_f3;
         mem_ready = c.ready;
         br_cond   = c.brc;
         trap_clr  = c.tclr;
         exp_o     = c.o;
         exp_ir    = m_instret;
         @(posedge clk);
         if (c.retire) m_instret = m_instret + 32'd1;
         #1;
      end
      chk_en = 1'b0;
   endtask

   task automatic do_instr(input logic [6:0] op, input logic [2:0] f3,
                           input int fwait, input int mwait, input logic brc);
      cur_op = op;
      cur_f3 = f3;
      build(op, f3, fwait, mwait, brc);
      run();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      int cnt;
      rst = 1'b1; opcode = '0; funct3 = '0; br_cond = 1'b0;
      mem_ready = 1'b0; trap_clr = 1'b0; chk_en = 1'b0;
      m_f3 = '0; m_instret = '0; cur_op = '0; cur_f3 = '0;
      n_tests = 0; n_fail = 0;

      @(posedge clk); #1;
      add(1'b1, 1'b0, 1'b0, base(), 1'b0);   // held in reset, inputs ignored
      add(1'b1, 1'b0, 1'b0, base(), 1'b0);
      run();
      rst = 1'b0;
      add(1'b0, 1'b0, 1'b0, base(), 1'b0);   // RESET state, FETCH next
      run();

      // ADD: four cycles, retires once
      cur_op = R_OP; cur_f3 = 3'b000;
      build(R_OP, 3'b000, 0, 0, 1'b0);
      check("add_len", 64'(tl.size()), 64'd4);
      run();
      check("add_instret", 64'(instret), 64'd1);

      // LW with three data wait cycles
      cur_op = LD_OP; cur_f3 = 3'b010;
      build(LD_OP, 3'b010, 0, 3, 1'b0);
      cnt = 0;
      foreach (tl[i]) if (tl[i].o.mem_req) cnt++;
      check("lw_memreq_cycles", 64'(cnt), 64'd5);
      run();
      check("lw_memtype", 64'(MemType), 64'd2);

      do_instr(ST_OP, 3'b010, 1, 1, 1'b0);   // SW
      do_instr(BR_OP, 3'b001, 0, 0, 1'b0);   // BNE not taken
      do_instr(BR_OP, 3'b001, 0, 0, 1'b1);   // BNE taken
      check("bne_branchtype", 64'(BranchType), 64'd1);
      do_instr(JAL_OP, 3'b000, 0, 0, 1'b0);
      do_instr(JR_OP, 3'b000, 2, 0, 1'b0);
      do_instr(IM_OP, 3'b100, 0, 0, 1'b0);
      do_instr(LUI_OP, 3'b011, 0, 0, 1'b0);
      do_instr(AUI_OP, 3'b110, 0, 0, 1'b0);
      check("instret_after_mix", 64'(instret), 64'd10);

      // Illegal opcode: trap cause 01, then back to FETCH with cause cleared
      do_instr(BAD_OP, 3'b111, 0, 0, 1'b0);
      check("illegal_cause_cleared", 64'({trap, trap_cause, mem_req}), 64'b0001);

      // Fetch never ready: trap cause 10 after four wait cycles
      cur_op = R_OP; cur_f3 = 3'b000;
      build(R_OP, 3'b000, 10, 0, 1'b0);
      cnt = 0;
      foreach (tl[i]) if (tl[i].o.mem_req && !tl[i].ready) cnt++;
      check("tmo_wait_cycles", 64'(cnt), 64'd4);
      run();
      do_instr(R_OP, 3'b000, 3, 0, 1'b0);    // ready just before expiry
      do_instr(LD_OP, 3'b101, 0, 3, 1'b0);

      // Reset in the middle of MEM: everything drops to zero at once
      cur_op = LD_OP; cur_f3 = 3'b010;
      build(LD_OP, 3'b010, 0, 3, 1'b0);
      while (tl.size() > 4) tl.delete(tl.size() - 1);
      run();
      check("pre_rst_memreq", 64'(mem_req), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_outs", 64'(dut_o), 64'd0);
      check("rst_instret", 64'(instret), 64'd0);
      m_f3 = '0; m_instret = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      add(1'b1, 1'b0, 1'b0, base(), 1'b0);
      run();
      do_instr(R_OP, 3'b000, 0, 0, 1'b0);
      check("post_rst_instret", 64'(instret), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
